bus_arbiter: RTL and testbench

- Two-master bus arbiter for the system bus top level. Shares the single bus between master 1 and master 2.
- Issues registered grants and drives the bus mux select.
- Reports per-master busy status; this is the source of the top-level m1_busy/m2_busy.
- Bounds bus ownership with a hold counter so one master cannot starve the other.

---
 rtl/bus_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_bus_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-master arbiter for the shared system bus. Grants are decoded straight
// from the registered FSM state, so they are glitch-free and never overlap.
// A hold counter bounds how long one master may keep the bus while the other
// is waiting; when it expires the holder is forced off for one dead cycle and
// the waiting master is granted next, regardless of the tie-break mode.
//
// Parameters
//   MAX_HOLD : max consecutive enabled cycles a master may hold the bus while
//              the other requests (0 disables preemption)
//   RR_MODE  : tie-break on simultaneous requests; 0 = M1 wins,
//              1 = the master that did not own the bus last wins
//
// Ports
//   clock     in   system clock, rising edge
//   rst       in   synchronous active-low reset (wins over ena)
//   ena       in   global enable, 0 freezes all state
//   m1_req    in   master 1 request (level, held for the transfer)
//   m2_req    in   master 2 request (level)
//   m1_grant  out  bus owned by master 1
//   m2_grant  out  bus owned by master 2
//   m1_busy   out  master 1 requesting while master 2 owns the bus
//   m2_busy   out  master 2 requesting while master 1 owns the bus
//   bus_sel   out  address/wdata mux select, 0 = M1, 1 = M2
//   preempt   out  one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter bit RR_MODE  = 1'b0
) (
  input  logic clock,
  input  logic rst,
  input  logic ena,
  input  logic m1_req,
  input  logic m2_req,
  output logic m1_grant,
  output logic m2_grant,
  output logic m1_busy,
  output logic m2_busy,
  output logic bus_sel,
  output logic preempt
);

  // Counter is wide enough to hold MAX_HOLD itself (saturation value).
  localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_SAT = CNT_W'(MAX_HOLD);
  // Last cycle a holder may keep the bus while the other master waits.
  localparam logic [CNT_W-1:0] HOLD_LIM = (MAX_HOLD == 0) ? CNT_W'(0) : CNT_W'(MAX_HOLD - 1);
  localparam bit PREEMPT_EN = (MAX_HOLD != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT1 = 2'd1,
    ST_GNT2 = 2'd2
  } state_e;

  typedef enum logic {
    OWN_M1 = 1'b0,
    OWN_M2 = 1'b1
  } owner_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  owner_e           last_owner_q, last_owner_d;
  logic             forced_q, forced_d;
  logic             m1_busy_q, m1_busy_d;
  logic             m2_busy_q, m2_busy_d;
  logic             bus_sel_q, bus_sel_d;
  logic             preempt_q, preempt_d;

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    last_owner_d = last_owner_q;
    forced_d     = forced_q;
    bus_sel_d    = bus_sel_q;
    m1_busy_d    = m1_busy_q;
    m2_busy_d    = m2_busy_q;
    preempt_d    = 1'b0;

    if (ena) begin
      // The forced flag only lives for the IDLE cycle that follows a
      // forced release; any other enabled cycle clears it.
      forced_d = 1'b0;

      case (state_q)
        ST_IDLE: begin
          // Cleared here so every grant state starts counting from zero.
          hold_cnt_d = CNT_W'(0);
          if (m1_req && m2_req) begin
            if (forced_q || RR_MODE) begin
              // Waiting / not-last master wins.
              state_d = (last_owner_q == OWN_M1) ? ST_GNT2 : ST_GNT1;
            end else begin
              state_d = ST_GNT1;
            end
          end else if (m1_req) begin
            state_d = ST_GNT1;
          end else if (m2_req) begin
            state_d = ST_GNT2;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_GNT1: begin
          hold_cnt_d = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
          if (!m1_req) begin
            state_d      = ST_IDLE;
            last_owner_d = OWN_M1;
          end else if (PREEMPT_EN && m2_req && (hold_cnt_q >= HOLD_LIM)) begin
            // >= also covers a request arriving after saturation.
            state_d      = ST_IDLE;
            last_owner_d = OWN_M1;
            forced_d     = 1'b1;
            preempt_d    = 1'b1;
          end else begin
            state_d = ST_GNT1;
          end
        end

        ST_GNT2: begin
          hold_cnt_d = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
          if (!m2_req) begin
            state_d      = ST_IDLE;
            last_owner_d = OWN_M2;
          end else if (PREEMPT_EN && m1_req && (hold_cnt_q >= HOLD_LIM)) begin
            state_d      = ST_IDLE;
            last_owner_d = OWN_M2;
            forced_d     = 1'b1;
            preempt_d    = 1'b1;
          end else begin
            state_d = ST_GNT2;
          end
        end

        default: begin
          state_d    = ST_IDLE;
          hold_cnt_d = CNT_W'(0);
        end
      endcase

      // bus_sel moves together with the grant; IDLE keeps the old value.
      case (state_d)
        ST_GNT1: bus_sel_d = 1'b0;
        ST_GNT2: bus_sel_d = 1'b1;
        default: bus_sel_d = bus_sel_q;
      endcase

      m1_busy_d = m1_req & (state_d == ST_GNT2);
      m2_busy_d = m2_req & (state_d == ST_GNT1);
    end else begin
      // Frozen: everything holds, only the preempt pulse is suppressed.
      preempt_d = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      hold_cnt_q   <= CNT_W'(0);
      last_owner_q <= OWN_M2;
      forced_q     <= 1'b0;
      m1_busy_q    <= 1'b0;
      m2_busy_q    <= 1'b0;
      bus_sel_q    <= 1'b0;
      preempt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      last_owner_q <= last_owner_d;
      forced_q     <= forced_d;
      m1_busy_q    <= m1_busy_d;
      m2_busy_q    <= m2_busy_d;
      bus_sel_q    <= bus_sel_d;
      preempt_q    <= preempt_d;
    end
  end

  assign m1_grant = (state_q == ST_GNT1);
  assign m2_grant = (state_q == ST_GNT2);
  assign m1_busy  = m1_busy_q;
  assign m2_busy  = m2_busy_q;
  assign bus_sel  = bus_sel_q;
  assign preempt  = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Three arbiter instances share one set of inputs:
//   A : MAX_HOLD=16, fixed priority
//   B : MAX_HOLD=16, round-robin
//   C : MAX_HOLD=0,  fixed priority (no preemption)
// Output vectors are packed as {m1_grant, m2_grant, m1_busy, m2_busy,
// bus_sel, preempt}. A vector table covers reset, single-master transfers,
// busy, dead cycle, freeze and reset priority; hand-written sequences cover
// hold-limit preemption, saturation, round-robin alternation and MAX_HOLD=0.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_i = 1'b0;
  logic ena_i = 1'b1;
  logic m1_i  = 1'b0;
  logic m2_i  = 1'b0;

  logic a_g1, a_g2, a_b1, a_b2, a_sel, a_pre;
  logic b_g1, b_g2, b_b1, b_b2, b_sel, b_pre;
  logic c_g1, c_g2, c_b1, c_b2, c_sel, c_pre;

  wire [5:0] out_a = {a_g1, a_g2, a_b1, a_b2, a_sel, a_pre};
  wire [5:0] out_b = {b_g1, b_g2, b_b1, b_b2, b_sel, b_pre};
  wire [5:0] out_c = {c_g1, c_g2, c_b1, c_b2, c_sel, c_pre};

  bus_arbiter #(.MAX_HOLD(16), .RR_MODE(1'b0)) dut_a (
    .clock(clock), .rst(rst_i), .ena(ena_i), .m1_req(m1_i), .m2_req(m2_i),
    .m1_grant(a_g1), .m2_grant(a_g2), .m1_busy(a_b1), .m2_busy(a_b2),
    .bus_sel(a_sel), .preempt(a_pre)
  );

  bus_arbiter #(.MAX_HOLD(16), .RR_MODE(1'b1)) dut_b (
    .clock(clock), .rst(rst_i), .ena(ena_i), .m1_req(m1_i), .m2_req(m2_i),
    .m1_grant(b_g1), .m2_grant(b_g2), .m1_busy(b_b1), .m2_busy(b_b2),
    .bus_sel(b_sel), .preempt(b_pre)
  );

  bus_arbiter #(.MAX_HOLD(0), .RR_MODE(1'b0)) dut_c (
    .clock(clock), .rst(rst_i), .ena(ena_i), .m1_req(m1_i), .m2_req(m2_i),
    .m1_grant(c_g1), .m2_grant(c_g2), .m1_busy(c_b1), .m2_busy(c_b2),
    .bus_sel(c_sel), .preempt(c_pre)
  );

  typedef struct packed {
    logic       rst;
    logic       ena;
    logic       m1;
    logic       m2;
    logic [5:0] exp;
  } vec_t;

  localparam int NVEC = 28;
  vec_t vecs [NVEC];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (g1 g2 b1 b2 sel pre)", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic e, input logic q1, input logic q2);
    @(negedge clock);
    rst_i = r;
    ena_i = e;
    m1_i  = q1;
    m2_i  = q2;
    @(posedge clock);
    #1;
    n_cmp++;
    if ((a_g1 & a_g2) | (b_g1 & b_g2) | (c_g1 & c_g2)) begin
      n_fail++;
      $display("FAIL overlap: a=%b%b b=%b%b c=%b%b required no double grant",
               a_g1, a_g2, b_g1, b_g2, c_g1, c_g2);
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    //              rst   ena   m1    m2    {g1 g2 b1 b2 sel pre}
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000000};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000000};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000000};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000000};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 6'b100000};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 6'b100000};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000000};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 6'b010010};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 6'b010010};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000010};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 6'b010010};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 6'b011010};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'b000010};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'b100000};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 6'b100100};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 6'b000000};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000000};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'b000000};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'b000000};
    vecs[19] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'b100000};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b100000};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b100000};
    vecs[22] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000000};
    vecs[23] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'b100000};
    vecs[24] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'b000000};
    vecs[25] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'b100000};
    vecs[26] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b000000};
    vecs[27] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000000};

    // No simultaneous request ever reaches IDLE in the table, so all three
    // configurations must agree with it.
    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].rst, vecs[i].ena, vecs[i].m1, vecs[i].m2);
      chk($sformatf("vec%0d_a", i), out_a, vecs[i].exp);
      chk($sformatf("vec%0d_b", i), out_b, vecs[i].exp);
      chk($sformatf("vec%0d_c", i), out_c, vecs[i].exp);
    end

    // Hold limit: M1 holds 16 cycles, preempt + dead cycle, then M2.
    // A freeze right after the preempt cycle must clear preempt but keep
    // the forced flag so M2 still wins with fixed priority.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk($sformatf("hold_gnt1_%0d", i), out_a, 6'b100100);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("hold_preempt", out_a, 6'b000001);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("hold_freeze_idle", out_a, 6'b000000);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("hold_gnt2", out_a, 6'b011010);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("hold_gnt2_next", out_a, 6'b011010);

    // Saturated counter: M1 alone for 20 cycles, M2 arrives -> release next edge.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk($sformatf("sat_gnt1_%0d", i), out_a, 6'b100000);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("sat_preempt", out_a, 6'b000001);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("sat_gnt2", out_a, 6'b011010);

    // Round-robin bursts: B alternates M1, M2, M1; A always picks M1.
    do_reset();
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 4; i++) begin
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk($sformatf("rr_b%0d_c%0d", b, i), out_b, (b == 1) ? 6'b011010 : 6'b100100);
        if (i == 0) begin
          chk($sformatf("fixed_b%0d", b), out_a, 6'b100100);
        end else begin
          chk($sformatf("fixed_b%0d_hold%0d", b, i), {out_a[5], out_a[0]}, 2'b10);
        end
      end
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("rr_b%0d_idle", b), out_b[5:4], 2'b00);
    end

    // Freeze during GNT2 stops the counter: 16 enabled cycles to preempt
    // despite 5 frozen ones in between. Then a request dropped while
    // frozen is only released after ena returns.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("frz_gnt2_first", out_a, 6'b010010);
    for (int i = 2; i <= 8; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk($sformatf("frz_gnt2_%0d", i), out_a, 6'b011010);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1);
      chk($sformatf("frz_hold_%0d", i), out_a, 6'b011010);
    end
    for (int i = 9; i <= 16; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk($sformatf("frz_gnt2_%0d", i), out_a, 6'b011010);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("frz_preempt", out_a, 6'b000011);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("frz_gnt1", out_a, 6'b100100);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk($sformatf("frz_drop_%0d", i), out_a, 6'b100100);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("frz_release", out_a, 6'b000000);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("frz_then_gnt2", out_a, 6'b010010);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("rst_mid_gnt2", out_a, 6'b000000);

    // MAX_HOLD=0: no preemption over 100 cycles; M2 granted 2 cycles after M1 drops.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk($sformatf("nohold_%0d", i), out_c, 6'b100100);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("nohold_dead", out_c, 6'b000000);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("nohold_gnt2", out_c, 6'b010010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
